// File: rtl/prog_timer_if.sv
// Control/status bundle for prog_timer: master drives the run controls, slave is the timer.
interface prog_timer_if #(
    parameter int WIDTH = 16,
    parameter int PRE_W = 8
);
    logic             start;
    logic             enable;
    logic             abort;
    logic             periodic;
    logic [WIDTH-1:0] load_val;
    logic [PRE_W-1:0] prescale;
    logic             trigger;
    logic             busy;
    logic             done;
    logic             cfg_err;
    logic [WIDTH-1:0] count;
    logic [1:0]       state;

    modport master (
        output start, enable, abort, periodic, load_val, prescale,
        input  trigger, busy, done, cfg_err, count, state
    );

    modport slave (
        input  start, enable, abort, periodic, load_val, prescale,
        output trigger, busy, done, cfg_err, count, state
    );
endinterface

// File: rtl/prog_timer.sv
// One-shot/periodic down-counting timer with prescaler; trigger pulses the cycle after the
// N*(P+1)-th clock from start. No backpressure: enable=0 pauses, abort/start act immediately.
module prog_timer #(
    parameter int WIDTH = 16,
    parameter int PRE_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    prog_timer_if.slave tif
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2,
        PAUSE = 2'd3
    } state_t;

    state_t           st;
    logic [WIDTH-1:0] cnt;
    logic [PRE_W-1:0] pre;
    logic [WIDTH-1:0] n_lat;
    logic [PRE_W-1:0] p_lat;
    logic             per_lat;
    logic             trigger_q;
    logic             cfg_err_q;
    logic             busy_q;
    logic             done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= IDLE;
            cnt       <= '0;
            pre       <= '0;
            n_lat     <= '0;
            p_lat     <= '0;
            per_lat   <= 1'b0;
            trigger_q <= 1'b0;
            cfg_err_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            trigger_q <= 1'b0;
            cfg_err_q <= 1'b0;
            if (tif.abort) begin
                st     <= IDLE;
                cnt    <= '0;
                pre    <= '0;
                busy_q <= 1'b0;
                done_q <= 1'b0;
            end else if (tif.start) begin
                if (tif.load_val != '0) begin
                    n_lat   <= tif.load_val;
                    p_lat   <= tif.prescale;
                    per_lat <= tif.periodic;
                    cnt     <= tif.load_val;
                    pre     <= '0;
                    st      <= COUNT;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                end else begin
                    cfg_err_q <= 1'b1;
                end
            end else begin
                case (st)
                    // Leaving PAUSE counts in the same cycle, so k cycles with enable low
                    // delay expiry by exactly k cycles.
                    COUNT, PAUSE: begin
                        if (!tif.enable) begin
                            st <= PAUSE;
                        end else begin
                            st <= COUNT;
                            if (pre == p_lat) begin
                                pre <= '0;
                                if (cnt == WIDTH'(1)) begin
                                    trigger_q <= 1'b1;
                                    if (per_lat) begin
                                        cnt <= n_lat;
                                    end else begin
                                        cnt    <= '0;
                                        st     <= DONE;
                                        busy_q <= 1'b0;
                                        done_q <= 1'b1;
                                    end
                                end else begin
                                    cnt <= cnt - WIDTH'(1);
                                end
                            end else begin
                                pre <= pre + PRE_W'(1);
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign tif.trigger = trigger_q;
    assign tif.cfg_err = cfg_err_q;
    assign tif.busy    = busy_q;
    assign tif.done    = done_q;
    assign tif.count   = cnt;
    assign tif.state   = st;
endmodule

// File: tb/tb_prog_timer.sv
// Scoreboard bench for prog_timer: expected snapshots and pulses are queued at stimulus time, a negedge monitor matches them.
module tb_prog_timer;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_PAUSE = 2'd3;

    typedef struct {
        int          dut;
        int          tag;
        int          cyc;
        logic [1:0]  st;
        logic [15:0] cnt;
        logic        bsy;
        logic        dn;
    } snap_t;

    typedef struct {
        int dut;
        int kind;   // 0 = trigger, 1 = cfg_err
        int cyc;
    } ev_t;

    logic  clk;
    logic  reset;
    int    cyc;
    int    checks;
    int    errors;
    logic  finishing;
    logic  flushed;
    snap_t snapq[$];
    ev_t   evq[$];

    prog_timer_if #(.WIDTH(16), .PRE_W(8)) ia ();
    prog_timer_if #(.WIDTH(4),  .PRE_W(8)) ib ();

    prog_timer #(.WIDTH(16), .PRE_W(8)) dut_a (.clk(clk), .reset(reset), .tif(ia));
    prog_timer #(.WIDTH(4),  .PRE_W(8)) dut_b (.clk(clk), .reset(reset), .tif(ib));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic exp_snap(input int d, input int tag, input int c, input logic [1:0] st,
                            input int cnt, input logic bsy, input logic dn);
        snap_t s;
        s.dut = d; s.tag = tag; s.cyc = c; s.st = st; s.cnt = 16'(cnt); s.bsy = bsy; s.dn = dn;
        snapq.push_back(s);
    endtask

    task automatic exp_ev(input int d, input int kind, input int c);
        ev_t e;
        e.dut = d; e.kind = kind; e.cyc = c;
        evq.push_back(e);
    endtask

    task automatic mon(input int d, input logic trg, input logic cerr, input logic [1:0] st,
                       input logic [15:0] cnt, input logic bsy, input logic dn);
        int   idx;
        logic hi;
        for (int k = 0; k < 2; k++) begin
            hi = (k == 0) ? trg : cerr;
            if (hi === 1'b1) begin
                idx = -1;
                foreach (evq[i])
                    if (evq[i].dut == d && evq[i].kind == k && evq[i].cyc == cyc) idx = i;
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL pulse dut%0d %s: high at cycle %0d, none expected then",
                             d, (k == 0) ? "trigger" : "cfg_err", cyc);
                end else begin
                    evq.delete(idx);
                end
            end
        end
        for (int i = snapq.size() - 1; i >= 0; i--) begin
            if (snapq[i].dut == d && snapq[i].cyc == cyc) begin
                checks++;
                if ({st, cnt, bsy, dn} !== {snapq[i].st, snapq[i].cnt, snapq[i].bsy, snapq[i].dn}) begin
                    errors++;
                    $display("FAIL snap dut%0d test%0d cycle %0d state/count/busy/done got %0d/%0d/%0b/%0b want %0d/%0d/%0b/%0b",
                             d, snapq[i].tag, cyc, st, cnt, bsy, dn,
                             snapq[i].st, snapq[i].cnt, snapq[i].bsy, snapq[i].dn);
                end
                snapq.delete(i);
            end
        end
    endtask

    initial begin
        flushed = 1'b0;
        checks  = 0;
        errors  = 0;
    end

    always @(negedge clk) begin
        mon(0, ia.trigger, ia.cfg_err, ia.state, ia.count, ia.busy, ia.done);
        mon(1, ib.trigger, ib.cfg_err, ib.state, {12'b0, ib.count}, ib.busy, ib.done);
        if (finishing && !flushed) begin
            foreach (evq[i]) begin
                checks++;
                errors++;
                $display("FAIL pulse dut%0d kind%0d: expected at cycle %0d, never seen",
                         evq[i].dut, evq[i].kind, evq[i].cyc);
            end
            foreach (snapq[i]) begin
                checks++;
                errors++;
                $display("FAIL snap dut%0d test%0d: cycle %0d never observed",
                         snapq[i].dut, snapq[i].tag, snapq[i].cyc);
            end
            evq.delete();
            snapq.delete();
            flushed = 1'b1;
        end
    end

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Drives start now (at a negedge); b is the edge that samples it.
    task automatic arm_start(input int d, input int n, input int p, input logic per, output int b);
        if (d == 0) begin
            ia.start = 1'b1; ia.load_val = 16'(n); ia.prescale = 8'(p); ia.periodic = per;
        end else begin
            ib.start = 1'b1; ib.load_val = 4'(n); ib.prescale = 8'(p); ib.periodic = per;
        end
        b = cyc + 1;
    endtask

    task automatic step1();
        @(negedge clk);
        ia.start = 1'b0; ia.abort = 1'b0;
        ib.start = 1'b0; ib.abort = 1'b0;
    endtask

    initial begin
        int b;
        int e;
        finishing = 1'b0;
        reset = 1'b1;
        ia.start = 0; ia.abort = 0; ia.enable = 1; ia.periodic = 0; ia.load_val = 0; ia.prescale = 0;
        ib.start = 0; ib.abort = 0; ib.enable = 1; ib.periodic = 0; ib.load_val = 0; ib.prescale = 0;
        exp_snap(0, 0, 2, S_IDLE, 0, 0, 0);
        exp_snap(1, 0, 2, S_IDLE, 0, 0, 0);
        exp_snap(0, 0, 5, S_IDLE, 0, 0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        goto(6);

        // one-shot N=5 P=0
        arm_start(0, 5, 0, 1'b0, b);
        exp_snap(0, 1, b,     S_COUNT, 5, 1, 0);
        exp_snap(0, 1, b + 4, S_COUNT, 1, 1, 0);
        exp_snap(0, 1, b + 5, S_DONE,  0, 0, 1);
        exp_snap(0, 1, b + 7, S_DONE,  0, 0, 1);
        exp_ev(0, 0, b + 5);
        step1();
        goto(b + 8);

        // zero load while DONE: rejected, state kept
        ia.start = 1'b1; ia.load_val = 16'd0;
        e = cyc + 1;
        exp_ev(0, 1, e);
        exp_snap(0, 5, e,     S_DONE, 0, 0, 1);
        exp_snap(0, 5, e + 1, S_DONE, 0, 0, 1);
        step1();
        goto(e + 2);

        // periodic N=3 P=1, then abort
        arm_start(0, 3, 1, 1'b1, b);
        exp_snap(0, 2, b,     S_COUNT, 3, 1, 0);
        exp_snap(0, 2, b + 1, S_COUNT, 3, 1, 0);
        exp_snap(0, 2, b + 2, S_COUNT, 2, 1, 0);
        exp_snap(0, 2, b + 3, S_COUNT, 2, 1, 0);
        exp_snap(0, 2, b + 4, S_COUNT, 1, 1, 0);
        exp_snap(0, 2, b + 5, S_COUNT, 1, 1, 0);
        exp_snap(0, 2, b + 6, S_COUNT, 3, 1, 0);
        exp_snap(0, 2, b + 20, S_IDLE, 0, 0, 0);
        exp_ev(0, 0, b + 6);
        exp_ev(0, 0, b + 12);
        exp_ev(0, 0, b + 18);
        step1();
        goto(b + 19);
        ia.abort = 1'b1;
        step1();
        goto(b + 26);

        // pause: enable low for 4 cycles
        arm_start(0, 10, 0, 1'b0, b);
        exp_snap(0, 3, b + 3,  S_COUNT, 7, 1, 0);
        exp_snap(0, 3, b + 4,  S_PAUSE, 7, 1, 0);
        exp_snap(0, 3, b + 7,  S_PAUSE, 7, 1, 0);
        exp_snap(0, 3, b + 8,  S_COUNT, 6, 1, 0);
        exp_snap(0, 3, b + 13, S_COUNT, 1, 1, 0);
        exp_snap(0, 3, b + 14, S_DONE,  0, 0, 1);
        exp_ev(0, 0, b + 14);
        step1();
        goto(b + 3);
        ia.enable = 1'b0;
        goto(b + 7);
        ia.enable = 1'b1;
        goto(b + 16);

        // restart reload, then abort+start together
        arm_start(0, 8, 0, 1'b0, b);
        exp_snap(0, 4, b + 2, S_COUNT, 6, 1, 0);
        exp_snap(0, 4, b + 3, S_COUNT, 8, 1, 0);
        exp_snap(0, 4, b + 5, S_IDLE,  0, 0, 0);
        exp_snap(0, 4, b + 7, S_IDLE,  0, 0, 0);
        step1();
        goto(b + 2);
        ia.start = 1'b1;
        step1();
        goto(b + 4);
        ia.start = 1'b1; ia.abort = 1'b1;
        step1();
        goto(b + 9);

        // zero load from IDLE, then reset mid-run
        ia.start = 1'b1; ia.load_val = 16'd0;
        e = cyc + 1;
        exp_ev(0, 1, e);
        exp_snap(0, 5, e, S_IDLE, 0, 0, 0);
        step1();
        goto(e + 2);
        arm_start(0, 6, 0, 1'b0, b);
        exp_snap(0, 5, b + 2, S_COUNT, 4, 1, 0);
        exp_snap(0, 5, b + 3, S_IDLE,  0, 0, 0);
        exp_snap(0, 5, b + 6, S_IDLE,  0, 0, 0);
        step1();
        goto(b + 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        goto(b + 7);

        // 4-bit timer at full-scale load
        arm_start(1, 15, 0, 1'b0, b);
        exp_snap(1, 6, b,      S_COUNT, 15, 1, 0);
        exp_snap(1, 6, b + 1,  S_COUNT, 14, 1, 0);
        exp_snap(1, 6, b + 14, S_COUNT, 1,  1, 0);
        exp_snap(1, 6, b + 15, S_DONE,  0,  0, 1);
        exp_snap(1, 6, b + 17, S_DONE,  0,  0, 1);
        exp_ev(1, 0, b + 15);
        step1();
        goto(b + 19);

        finishing = 1'b1;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
